qr_to_bcd: RTL

- Sequential decimal digit generator for the float-to-decimal path.
- Sits directly downstream of the mantissa split stage, which produces a 24-bit integer part Q and a 24-bit left-aligned fraction R. The binary point of R is above bit 23.
- Converts Q to 8 packed-BCD digits using iterative shift-add-3 (double dabble), one bit per clock.
- Converts R to FRAC_DIGITS packed-BCD digits using repeated multiply-by-10, one digit per clock.
- Sign is passed through for the display/format stage.

---
 rtl/qr_to_bcd_if.sv | 25 ++
 rtl/qr_to_bcd.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/qr_to_bcd_if.sv
// Handshake and data bundle for the qr_to_bcd digit generator.
// master: upstream requester / result consumer. slave: the converter.
interface qr_to_bcd_if #(
    parameter int FRAC_DIGITS = 4
);
    logic                     start;
    logic                     sign_in;
    logic [23:0]              q_in;
    logic [23:0]              r_in;
    logic                     busy;
    logic                     done;
    logic                     sign_out;
    logic [31:0]              int_bcd;
    logic [4*FRAC_DIGITS-1:0] frac_bcd;

    modport master (
        output start, sign_in, q_in, r_in,
        input  busy, done, sign_out, int_bcd, frac_bcd
    );

    modport slave (
        input  start, sign_in, q_in, r_in,
        output busy, done, sign_out, int_bcd, frac_bcd
    );
endinterface

// File: rtl/qr_to_bcd.sv
// qr_to_bcd: sequential decimal digit generator for the float-to-decimal path.
// Integer part Q (24 bit) -> 8 packed-BCD digits by double dabble, one bit/clock.
// Fraction R (24 bit, binary point above bit 23) -> FRAC_DIGITS packed-BCD digits
// by repeated multiply-by-10, one digit/clock.
// Optional feature macro QR_TO_BCD_ROUND_EN: adds a ROUND state that rounds the
// combined {int, frac} decimal result half-up on the leftover fraction bit.
//
// state | meaning
// IDLE  | waiting for start; inputs captured when start=1
// INT   | 24 shift-add-3 steps over Q
// FRAC  | FRAC_DIGITS multiply-by-10 steps over R
// ROUND | (macro only) single-cycle BCD increment if remainder >= 0.5 ulp
// DONE  | result visible on outputs, done pulse, back to IDLE
module qr_to_bcd #(
    parameter int FRAC_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    qr_to_bcd_if.slave  bus
);
    localparam int FW = 4 * FRAC_DIGITS;

`ifdef QR_TO_BCD_ROUND_EN
    typedef enum logic [2:0] {IDLE, INT, FRAC, ROUND, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, INT, FRAC, DONE} state_t;
`endif

    state_t state, state_nxt;

    logic [23:0]   q_w;
    logic [23:0]   r_w;
    logic [31:0]   bcd_w;
    logic [FW-1:0] frac_w;
    logic          sign_w;
    logic [4:0]    cnt;
    logic          cnt_tc;

    logic [31:0]   int_r;
    logic [FW-1:0] frac_r;
    logic          sign_r;

    logic [31:0]   bcd_adj;
    logic [55:0]   dd_shift;
    logic [27:0]   acc;
    logic [FW-1:0] frac_nxt;

    assign cnt_tc = (cnt == 5'd0);

    // Double-dabble correction and shift, and the multiply-by-10 digit step.
    always_comb begin
        bcd_adj = bcd_w;
        for (int i = 0; i < 8; i++) begin
            if (bcd_w[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_w[4*i +: 4] + 4'd3;
            end
        end
        dd_shift = {bcd_adj, q_w} << 1;
        acc      = ({4'b0, r_w} << 3) + ({4'b0, r_w} << 1);
        frac_nxt = (frac_w << 4) | FW'(acc[27:24]);
    end

`ifdef QR_TO_BCD_ROUND_EN
    logic [FW+31:0] rnd_in;
    logic [FW+31:0] rnd_out;
    logic           rnd_carry;

    // Chained per-digit BCD incrementer over {int, frac}; carry seeded by r[23].
    always_comb begin
        rnd_in    = {bcd_w, frac_w};
        rnd_out   = rnd_in;
        rnd_carry = r_w[23];
        for (int i = 0; i < 8 + FRAC_DIGITS; i++) begin
            if (rnd_carry) begin
                if (rnd_in[4*i +: 4] == 4'd9) begin
                    rnd_out[4*i +: 4] = 4'd0;
                end else begin
                    rnd_out[4*i +: 4] = rnd_in[4*i +: 4] + 4'd1;
                    rnd_carry         = 1'b0;
                end
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the down-counter terminal count ends INT and FRAC.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = INT;
            INT:   if (cnt_tc) state_nxt = FRAC;
`ifdef QR_TO_BCD_ROUND_EN
            FRAC:  if (cnt_tc) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
`else
            FRAC:  if (cnt_tc) state_nxt = DONE;
`endif
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers and result registers; results only change on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_w    <= '0;
            r_w    <= '0;
            bcd_w  <= '0;
            frac_w <= '0;
            sign_w <= 1'b0;
            cnt    <= '0;
            int_r  <= '0;
            frac_r <= '0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_w    <= bus.q_in;
                        r_w    <= bus.r_in;
                        sign_w <= bus.sign_in;
                        bcd_w  <= '0;
                        frac_w <= '0;
                        cnt    <= 5'd23;
                    end
                end
                INT: begin
                    bcd_w <= dd_shift[55:24];
                    q_w   <= dd_shift[23:0];
                    cnt   <= cnt_tc ? 5'(FRAC_DIGITS - 1) : cnt - 5'd1;
                end
                FRAC: begin
                    frac_w <= frac_nxt;
                    r_w    <= acc[23:0];
                    if (!cnt_tc) begin
                        cnt <= cnt - 5'd1;
                    end
`ifndef QR_TO_BCD_ROUND_EN
                    else begin
                        int_r  <= bcd_w;
                        frac_r <= frac_nxt;
                        sign_r <= sign_w;
                    end
`endif
                end
`ifdef QR_TO_BCD_ROUND_EN
                ROUND: begin
                    int_r  <= rnd_out[FW+31:FW];
                    frac_r <= rnd_out[FW-1:0];
                    sign_r <= sign_w;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE) && (state != DONE);
    assign bus.done     = (state == DONE);
    assign bus.int_bcd  = int_r;
    assign bus.frac_bcd = frac_r;
    assign bus.sign_out = sign_r;

endmodule
